fir_out_requant: RTL and testbench
==================================

// Module: fir_out_requant
// PURPOSE
//  Output stage directly downstream of the pipelined FIR MAC chain. Takes the wide signed
//  filter sum and rounds it (round-half-up) by a fixed arithmetic right shift that removes
//  the coefficient fraction bits, then saturates it to the output sample width.
//  Buffers results in a small first-word-fall-through FIFO with a valid/ready interface and
//  keeps saturation and drop statistics.
// PARAMETERS
//  DATA_IN_WIDTH   64  width of signed FIR sum input
//  DATA_OUT_WIDTH  16  width of signed requantized output sample
//  SHIFT           23  arithmetic right shift (tap fraction bits); 0 = no shift, no rounding
//  FIFO_DEPTH      8   output FIFO entries (power of 2, >=2)
//  CNT_WIDTH       16  width of statistics counters
// PORTS
//  clk            in   1                      rising-edge clock
//  reset          in   1                      synchronous, active-high reset
//  in_valid       in   1                      in_data valid this cycle (no backpressure upstream)
//  in_data        in   DATA_IN_WIDTH          signed FIR sum
//  out_ready      in   1                      downstream accepts out_data this cycle
//  out_valid      out  1                      FIFO non-empty; out_data valid
//  out_data       out  DATA_OUT_WIDTH         signed sample at FIFO head
//  fifo_level     out  $clog2(FIFO_DEPTH+1)   FIFO occupancy, 0..FIFO_DEPTH
//  sat_count      out  CNT_WIDTH              number of saturated samples
//  drop_count     out  CNT_WIDTH              number of samples lost on full FIFO
//  overflow_flag  out  1                      sticky: at least one drop since last clear
//  clear_stats    in   1                      synchronous clear of counters and overflow_flag
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO emptied, pointers 0; s1_valid = s2_valid = 0. Mid-operation
//    reset discards pipeline and FIFO contents; outputs are 0 from the next cycle.
//  - S1 (register): s1_valid <= in_valid; s1_sum <= sext(in_data) + 2^(SHIFT-1), computed
//    in DATA_IN_WIDTH+1 bits so there is no wrap. The add is omitted when SHIFT = 0.
//  - S2 (register): s2_valid <= s1_valid; q = s1_sum >>> SHIFT.
//    q > 2^(DATA_OUT_WIDTH-1)-1 -> max. q < -2^(DATA_OUT_WIDTH-1) -> min.
//    Set s2_sat when q is clipped. Otherwise take the low DATA_OUT_WIDTH bits.
//  - Stage data registers update only when the stage valid is 1. Valid bits always update.
//  - FIFO write when s2_valid = 1. pop = out_valid & out_ready.
//  - Full and no pop: the sample is dropped. drop_count is incremented and overflow_flag is set.
//  - Full and pop in the same cycle: the write is accepted and the level is unchanged.
//  - Empty: a write is not visible on out_data until the next cycle. There is no bypass.
//  - out_data is the FIFO head (FWFT). out_data and out_valid must hold stable while
//    out_valid & !out_ready. out_data is don't-care when out_valid = 0.
//  - Latency: in_valid in cycle 0 -> S1 in cycle 1, S2 in cycle 2, out_valid/out_data in
//    cycle 3 (FIFO empty). Throughput is 1 sample/cycle.
//  - sat_count increments per saturated S2 sample, whether that sample is stored or dropped.
//  - Counters saturate at all-ones and never wrap.
//  - clear_stats zeroes sat_count, drop_count and overflow_flag, and wins over a
//    same-cycle increment. It does not affect the FIFO or the pipeline.
//  - Pointers wrap modulo FIFO_DEPTH. fifo_level is exact, with no off-by-one at full.
// TESTING
//  1 Rounding, SHIFT=23. in_data 2^22 -> 1; 2^22-1 -> 0; -2^22 -> 0; -2^22-1 -> -1;
//    3*2^23 -> 3. sat_count stays 0.
//  2 Saturation. in_data 2^40 -> 0x7FFF; -2^40 -> 0x8000; 2^38-1 -> 0x7FFF.
//    sat_count = 3, and the next in-range sample passes unclipped.
//  3 Latency. Single in_valid pulse with value 2^23, FIFO empty, out_ready=1 -> out_valid
//    is high only in cycle 3 with out_data=1, and fifo_level returns to 0.
//  4 Backpressure. out_ready=0 with 10 consecutive samples 1..10 (scaled by 2^23) ->
//    fifo_level=8, drop_count=2, overflow_flag=1. Then out_ready=1 -> 1..8 read out in order.
//  5 Full plus pop. FIFO full, out_ready=1, continuous input -> drop_count unchanged,
//    fifo_level stays 8, and the order is preserved.
//  6 Reset/clear. Assert reset with 5 entries queued -> next cycle out_valid=0 and
//    fifo_level=0. clear_stats while a drop occurs -> drop_count=0 and overflow_flag=0.

Source files
------------

// File: rtl/fir_out_requant.sv
// FIR output requantizer: round-half-up arithmetic shift, saturation to the sample width,
// a first-word-fall-through output FIFO with valid/ready, and saturation/drop statistics.
module fir_out_requant #(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int SHIFT          = 23,
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [DATA_IN_WIDTH-1:0]           in_data,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [DATA_OUT_WIDTH-1:0]          out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic [CNT_WIDTH-1:0]               sat_count,
    output logic [CNT_WIDTH-1:0]               drop_count,
    output logic                               overflow_flag,
    input  logic                               clear_stats
);

    localparam int SW      = DATA_IN_WIDTH + 1;
    localparam int LW      = $clog2(FIFO_DEPTH + 1);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [SW-1:0]        ROUND_ADD  = (SHIFT > 0) ? (SW'(1) << RND_POS) : '0;
    localparam logic signed [SW-1:0] Q_MAX      = {{(SW-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] Q_MIN      = {{(SW-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};
    localparam logic [LW-1:0]        FULL_LEVEL = LW'(FIFO_DEPTH);

    logic                           s1_valid;
    logic signed [SW-1:0]           s1_sum;
    logic                           s2_valid;
    logic                           s2_sat;
    logic [DATA_OUT_WIDTH-1:0]      s2_data;

    logic signed [SW-1:0]           q;
    logic [DATA_OUT_WIDTH-1:0]      q_clip;
    logic                           q_sat;

    logic [DATA_OUT_WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]                  wr_ptr;
    logic [PW-1:0]                  rd_ptr;
    logic                           full;
    logic                           pop;
    logic                           push;
    logic                           drop;

    // Sign-extend one bit so the rounding offset can never wrap the sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid)
                s1_sum <= $signed({in_data[DATA_IN_WIDTH-1], in_data}) + $signed(ROUND_ADD);
        end
    end

    assign q = s1_sum >>> SHIFT;

    always_comb begin
        q_clip = q[DATA_OUT_WIDTH-1:0];
        q_sat  = 1'b0;
        if (q > Q_MAX) begin
            q_clip = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
            q_sat  = 1'b1;
        end else if (q < Q_MIN) begin
            q_clip = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
            q_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sat  <= q_sat;
                s2_data <= q_clip;
            end
        end
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign out_valid = (fifo_level != '0);
    assign full      = (fifo_level == FULL_LEVEL);
    assign pop       = out_valid & out_ready;
    assign push      = s2_valid & (~full | pop);
    assign drop      = s2_valid & full & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s2_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                fifo_level <= fifo_level + LW'(1);
            else if (pop && !push)
                fifo_level <= fifo_level - LW'(1);
        end
    end

    // Counters stick at all-ones; clear_stats overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            sat_count     <= '0;
            drop_count    <= '0;
            overflow_flag <= 1'b0;
        end else begin
            if (s2_valid && s2_sat && !(&sat_count))
                sat_count <= sat_count + CNT_WIDTH'(1);
            if (drop && !(&drop_count))
                drop_count <= drop_count + CNT_WIDTH'(1);
            if (drop)
                overflow_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: rounding/saturation vector table, then hand-written
// latency, backpressure, full-plus-pop, reset and clear sequences.
module tb_fir_out_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [3:0]  fifo_level;
    logic [15:0] sat_count;
    logic [15:0] drop_count;
    logic        overflow_flag;
    logic        clear_stats;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] din;
        logic [15:0] dout;
        int          sat;
    } vec_t;

    vec_t vecs [13];

    fir_out_requant dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .fifo_level   (fifo_level),
        .sat_count    (sat_count),
        .drop_count   (drop_count),
        .overflow_flag(overflow_flag),
        .clear_stats  (clear_stats)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitOut(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL %s: out_valid never rose within 10 cycles", name);
        end
    endtask

    function automatic logic [63:0] scaled(input int v);
        return 64'(v) << 23;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;

        vecs[0]  = '{64'd1 << 22,                          16'h0001, 0};
        vecs[1]  = '{(64'd1 << 22) - 64'd1,                16'h0000, 0};
        vecs[2]  = '{-(64'd1 << 22),                       16'h0000, 0};
        vecs[3]  = '{-(64'd1 << 22) - 64'd1,               16'hFFFF, 0};
        vecs[4]  = '{64'd3 << 23,                          16'h0003, 0};
        vecs[5]  = '{64'd1 << 40,                          16'h7FFF, 1};
        vecs[6]  = '{-(64'd1 << 40),                       16'h8000, 2};
        vecs[7]  = '{(64'd1 << 38) - 64'd1,                16'h7FFF, 3};
        vecs[8]  = '{64'd100 << 23,                        16'h0064, 3};
        vecs[9]  = '{64'd32767 << 23,                      16'h7FFF, 3};
        vecs[10] = '{-(64'd32768 << 23),                   16'h8000, 3};
        vecs[11] = '{(64'd32767 << 23) + (64'd1 << 22),    16'h7FFF, 4};
        vecs[12] = '{64'h7FFF_FFFF_FFFF_FFFF,              16'h7FFF, 5};

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset fifo_level", fifo_level, 0);
        checkOutput("reset sat_count", sat_count, 0);
        checkOutput("reset drop_count", drop_count, 0);
        checkOutput("reset overflow", overflow_flag, 0);

        // Rounding and saturation table
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].din);
            waitOut($sformatf("vec%0d wait", i), ok);
            if (ok) begin
                checkOutput($sformatf("vec%0d data", i), out_data, vecs[i].dout);
                checkOutput($sformatf("vec%0d sat_count", i), sat_count, 64'(vecs[i].sat));
            end
        end
        tick();
        checkOutput("table drop_count", drop_count, 0);

        // Latency: single pulse, output only in cycle 3
        in_valid = 1'b1;
        in_data  = scaled(1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            in_valid = 1'b0;
            checkOutput($sformatf("latency c%0d valid", c), out_valid, 64'(c == 3));
            if (c == 3)
                checkOutput("latency data", out_data, 1);
        end
        checkOutput("latency level", fifo_level, 0);

        // Backpressure: 10 samples into an 8-deep FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = scaled(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        checkOutput("bp level", fifo_level, 8);
        checkOutput("bp drop_count", drop_count, 2);
        checkOutput("bp overflow", overflow_flag, 1);
        checkOutput("bp head hold", out_data, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("bp read%0d valid", k), out_valid, 1);
            checkOutput($sformatf("bp read%0d data", k), out_data, 64'(k));
            tick();
        end
        checkOutput("bp drained level", fifo_level, 0);

        // Full plus pop: write and pop land on the same edge
        out_ready = 1'b0;
        for (int i = 11; i <= 18; i++) begin
            in_valid = 1'b1;
            in_data  = scaled(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        checkOutput("fp fill level", fifo_level, 8);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = scaled(19 + i);
            if (i >= 2) begin
                out_ready = 1'b1;
                checkOutput($sformatf("fp step%0d data", i), out_data, 64'(11 + i - 2));
                checkOutput($sformatf("fp step%0d level", i), fifo_level, 8);
            end
            tick();
        end
        in_valid = 1'b0;
        checkOutput("fp drop_count", drop_count, 2);
        for (int k = 21; k <= 30; k++) begin
            checkOutput($sformatf("fp tail%0d valid", k), out_valid, 1);
            checkOutput($sformatf("fp tail%0d data", k), out_data, 64'(k));
            tick();
        end
        checkOutput("fp drained level", fifo_level, 0);

        // Reset with 5 entries queued and one sample in flight
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            applyStimulus(scaled(i));
        tick(); tick(); tick();
        checkOutput("rst queued level", fifo_level, 5);
        applyStimulus(scaled(6));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst level", fifo_level, 0);
        checkOutput("rst drop_count", drop_count, 0);
        checkOutput("rst sat_count", sat_count, 0);
        tick(); tick(); tick();
        checkOutput("rst pipeline flushed", fifo_level, 0);

        // clear_stats coinciding with a drop
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1;
            in_data  = scaled(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        checkOutput("clr pre drop_count", drop_count, 1);
        checkOutput("clr pre overflow", overflow_flag, 1);
        applyStimulus(scaled(40));
        tick();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        checkOutput("clr drop_count", drop_count, 0);
        checkOutput("clr overflow", overflow_flag, 0);
        checkOutput("clr level kept", fifo_level, 8);
        checkOutput("clr head kept", out_data, 1);
        applyStimulus(scaled(41));
        tick(); tick();
        checkOutput("post clr drop_count", drop_count, 1);
        checkOutput("post clr overflow", overflow_flag, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
